elastic_pipeline_reg: RTL and testbench

ELASTIC_PIPELINE_REG -- requirements
Module: elastic_pipeline_reg

---
 rtl/elastic_pipeline_reg_pkg.sv | 22 ++
 rtl/elastic_pipeline_reg_storage.sv | 25 ++
 rtl/elastic_pipeline_reg.sv | 79 +++++++
 tb/tb_elastic_pipeline_reg.sv | 122 ++++++++++++
 4 files changed

// File: rtl/elastic_pipeline_reg_pkg.sv
// Shared IF/ID pipeline definitions: payload field widths, NOP encoding and
// the bubble payload presented by an empty pipeline buffer.
package elastic_pipeline_reg_pkg;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;
   localparam int IF_ID_W = PC_W + INSTR_W;

   // addi x0, x0, 0
   localparam logic [INSTR_W-1:0] NOP_INSTR      = 32'h00000013;
   localparam logic [IF_ID_W-1:0] BUBBLE_DEFAULT = {32'd0, NOP_INSTR};

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } if_id_t;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/elastic_pipeline_reg_storage.sv
// Entry storage for the elastic pipeline buffer: one write port, one
// asynchronous read port, no reset (contents are don't-care when not valid).
module pipe_buf_storage #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 2,
   parameter int PTR_W      = 1
) (
   input  logic                  CLK,
   input  logic                  wr_en,
   input  logic [PTR_W-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [PTR_W-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/elastic_pipeline_reg.sv
// Elastic FIFO pipeline register between pipeline stages, with global stall
// (BUSYWAIT), redirect flush and a bubble payload when empty.
module elastic_pipeline_reg
   import elastic_pipeline_reg_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 64,
   parameter int                    DEPTH        = 2,
   parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = DATA_WIDTH'(BUBBLE_DEFAULT)
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic [DATA_WIDTH-1:0]        IN_DATA,
   input  logic                         IN_VALID,
   output logic                         IN_READY,
   output logic [DATA_WIDTH-1:0]        OUT_DATA,
   output logic                         OUT_VALID,
   input  logic                         OUT_READY,
   input  logic                         BUSYWAIT,
   input  logic                         FLUSH,
   output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
);

   localparam int                PTR_W = ptr_width(DEPTH);
   localparam int                OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]  LAST  = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0]  FULL  = OCC_W'(DEPTH);

   if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("elastic_pipeline_reg: DEPTH must be in 1..4");
   end

   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [OCC_W-1:0]      occ;
   logic [DATA_WIDTH-1:0] head;
   logic                  push, pop;

   // IN_READY deliberately ignores OUT_READY: a full buffer never pushes on a pop cycle.
   assign IN_READY  = (occ != FULL) && !BUSYWAIT;
   assign OUT_VALID = (occ != '0);
   assign push      = IN_VALID && IN_READY && !FLUSH && !RESET;
   assign pop       = OUT_VALID && OUT_READY && !BUSYWAIT && !FLUSH && !RESET;

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge CLK) begin
      if (RESET || FLUSH) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wrap_inc(wr_ptr);
         if (pop)  rd_ptr <= wrap_inc(rd_ptr);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   pipe_buf_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .PTR_W      (PTR_W)
   ) u_storage (
      .CLK     (CLK),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (IN_DATA),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   assign OUT_DATA  = OUT_VALID ? head : BUBBLE_VALUE;
   assign OCCUPANCY = occ;

endmodule

// File: tb/tb_elastic_pipeline_reg.sv
// Bench for elastic_pipeline_reg: DEPTH=2 and DEPTH=3 instances share stimulus,
// each compared every cycle against a queue-based reference model.
module tb_elastic_pipeline_reg;

   localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;
   localparam logic [63:0] VA     = 64'h0000_0004_0000_0093;
   localparam logic [63:0] VB     = 64'h0000_0008_0000_0113;
   localparam logic [63:0] VC     = 64'h0000_000C_0000_0193;
   localparam logic [63:0] VD     = 64'h0000_0010_0000_0213;

   logic        clk = 1'b0;
   logic        rst, iv, ordy, bw, fl;
   logic [63:0] din;

   logic [1:0]  in_rdy, out_vld;
   logic [63:0] out_data [2];
   logic [1:0]  occ [2];

   logic [63:0] mq [2][$];
   int          dep [2] = '{2, 3};
   int          vectors = 0;
   int          errs    = 0;

   always #5 clk = ~clk;

   elastic_pipeline_reg #(.DATA_WIDTH(64), .DEPTH(2)) dut2 (
      .CLK(clk), .RESET(rst), .IN_DATA(din), .IN_VALID(iv), .IN_READY(in_rdy[0]),
      .OUT_DATA(out_data[0]), .OUT_VALID(out_vld[0]), .OUT_READY(ordy),
      .BUSYWAIT(bw), .FLUSH(fl), .OCCUPANCY(occ[0])
   );

   elastic_pipeline_reg #(.DATA_WIDTH(64), .DEPTH(3)) dut3 (
      .CLK(clk), .RESET(rst), .IN_DATA(din), .IN_VALID(iv), .IN_READY(in_rdy[1]),
      .OUT_DATA(out_data[1]), .OUT_VALID(out_vld[1]), .OUT_READY(ordy),
      .BUSYWAIT(bw), .FLUSH(fl), .OCCUPANCY(occ[1])
   );

   task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s depth%0d t=%0t: got %h want %h", nm, dep[i], $time, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then advance the model by what the edge should do.
   task automatic cyc(input logic v, input logic [63:0] d, input logic r,
                      input logic b, input logic f, input logic rs);
      iv = v; din = d; ordy = r; bw = b; fl = f; rst = rs;
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (rs || f) mq[i].delete();
         else if (!b) begin
            int sz;
            sz = mq[i].size();
            if (r && sz != 0) void'(mq[i].pop_front());
            if (v && sz != dep[i]) mq[i].push_back(d);
         end
      end
      #1;
   endtask

   // Monitor: compare both DUTs to the model away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            logic [63:0] eh;
            eh = (mq[i].size() != 0) ? mq[i][0] : BUBBLE;
            chk("out_valid", i, 64'(out_vld[i]), 64'(mq[i].size() != 0));
            chk("out_data",  i, out_data[i], eh);
            chk("in_ready",  i, 64'(in_rdy[i]), 64'((mq[i].size() != dep[i]) && !bw));
            chk("occupancy", i, 64'(occ[i]), 64'(mq[i].size()));
         end
      end
   end

   initial begin
      repeat (2) cyc(0, '0, 0, 0, 0, 1);

      // two pushes with downstream stalled, then hold
      cyc(1, VA, 0, 0, 0, 0);
      cyc(1, VB, 0, 0, 0, 0);
      cyc(0, '0, 0, 0, 0, 0);
      // pop while full and offering C
      repeat (2) cyc(1, VC, 1, 0, 0, 0);
      repeat (3) cyc(0, '0, 1, 0, 0, 0);

      // stall holds everything
      cyc(1, VA, 0, 0, 0, 0);
      repeat (3) cyc(1, VB, 1, 1, 0, 0);
      repeat (2) cyc(0, '0, 1, 0, 0, 0);

      // flush beats busywait on a full buffer
      for (int k = 1; k <= 3; k++) cyc(1, 64'(k) << 8, 0, 0, 0, 0);
      cyc(1, VC, 0, 1, 1, 0);
      cyc(0, '0, 0, 0, 0, 0);

      // continuous streaming across pointer wrap
      cyc(0, '0, 0, 0, 0, 1);
      for (int k = 1; k <= 10; k++) cyc(1, 64'(k), 1, 0, 0, 0);
      repeat (3) cyc(0, '0, 1, 0, 0, 0);

      // reset while full, then first push after release
      for (int k = 1; k <= 3; k++) cyc(1, 64'(k) << 16, 0, 0, 0, 0);
      cyc(1, VC, 0, 0, 0, 1);
      cyc(1, VD, 0, 0, 0, 0);
      repeat (2) cyc(0, '0, 1, 0, 0, 0);

      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(99) < 70, {$urandom, $urandom}, $urandom_range(99) < 55,
             $urandom_range(99) < 10, $urandom_range(99) < 3, $urandom_range(199) == 0);
      end

      cyc(0, '0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
